// File: rtl/inst_queue_pkg.sv
// Shared widths and the queue entry layout for inst_queue.
// INSTQ_BPU_INFO_EN adds 33-bit branch-prediction info to every entry.
package inst_queue_pkg;

    localparam int InstBus      = 32;
    localparam int InstAddrBus  = 32;
    localparam int BpuInfoWidth = 33;

    // One stored instruction; the prediction field exists only when enabled.
    typedef struct packed {
`ifdef INSTQ_BPU_INFO_EN
        logic [BpuInfoWidth-1:0] bpu;
`endif
        logic [InstAddrBus-1:0]  pc;
        logic [InstBus-1:0]      inst;
    } iq_entry_t;

    localparam int EntryW = $bits(iq_entry_t);

    // Number of set bits in a lane mask of up to four lanes.
    function automatic logic [2:0] popcnt4(input logic [3:0] m);
        popcnt4 = 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction

endpackage

// File: rtl/inst_queue_mem.sv
// Circular entry storage: consecutive-address multi-lane write, and
// multi-lane combinational read, both from a base index that wraps mod DEPTH.
module inst_queue_mem #(
    parameter int DEPTH     = 32,
    parameter int W         = 64,
    parameter int IN_LANES  = 2,
    parameter int OUT_LANES = 2
) (
    input  logic                       clk,
    input  logic [IN_LANES-1:0]        we_i,
    input  logic [$clog2(DEPTH)-1:0]   wbase_i,
    input  logic [IN_LANES*W-1:0]      wdata_i,
    input  logic [$clog2(DEPTH)-1:0]   rbase_i,
    output logic [OUT_LANES*W-1:0]     rdata_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];

    // Lane k lands at wbase+k; the AW-bit sum wraps naturally past DEPTH-1.
    always_ff @(posedge clk) begin
        for (int k = 0; k < IN_LANES; k++) begin
            if (we_i[k]) begin
                mem_q[wbase_i + AW'(k)] <= wdata_i[k*W +: W];
            end
        end
    end

    for (genvar k = 0; k < OUT_LANES; k++) begin : g_rd
        assign rdata_o[k*W +: W] = mem_q[rbase_i + AW'(k)];
    end

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between fetch and issue: pointers, exact occupancy count,
// back-pressure flags and sticky overflow. Storage lives in inst_queue_mem.
// Optional feature macro: INSTQ_BPU_INFO_EN (per-entry prediction info ports).
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH       = 32,
    parameter int IN_LANES    = 2,
    parameter int OUT_LANES   = 2,
    parameter int AFULL_SLACK = 6
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush_i,
    input  logic [IN_LANES-1:0]                 push_valid_i,
    input  logic [IN_LANES*InstBus-1:0]         push_inst_i,
    input  logic [IN_LANES*InstAddrBus-1:0]     push_pc_i,
`ifdef INSTQ_BPU_INFO_EN
    input  logic [IN_LANES*BpuInfoWidth-1:0]    push_bpu_i,
`endif
    input  logic [$clog2(OUT_LANES+1)-1:0]      pop_num_i,
    output logic [OUT_LANES-1:0]                out_valid_o,
    output logic [OUT_LANES*InstBus-1:0]        out_inst_o,
    output logic [OUT_LANES*InstAddrBus-1:0]    out_pc_o,
`ifdef INSTQ_BPU_INFO_EN
    output logic [OUT_LANES*BpuInfoWidth-1:0]   out_bpu_o,
`endif
    output logic [$clog2(DEPTH+1)-1:0]          count_o,
    output logic                                empty_o,
    output logic                                full_o,
    output logic                                almost_full_o,
    output logic                                overflow_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0]              head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       overflow_q, overflow_d;
    logic [2:0]                 n_push;
    logic [CW-1:0]              n_pop;
    logic                       push_ok;
    logic [IN_LANES-1:0]        wr_en;
    logic [IN_LANES*EntryW-1:0] wr_data;
    logic [OUT_LANES*EntryW-1:0] rd_data;

    assign n_push = popcnt4(4'(push_valid_i));

    // Accept the whole group only if it fits against the current count; a
    // same-cycle pop is deliberately not credited.
    always_comb begin
        push_ok = ({1'b0, count_q} + (CW+1)'(n_push)) <= (CW+1)'(DEPTH);
    end

    // Pop is clamped to what is present and to the number of output lanes.
    always_comb begin
        n_pop = CW'(pop_num_i);
        if (n_pop > count_q)         n_pop = count_q;
        if (n_pop > CW'(OUT_LANES))  n_pop = CW'(OUT_LANES);
    end

    // Pointer/count/overflow next state; flush overrides push and pop.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush_i) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (n_push != 3'd0) begin
                if (push_ok) tail_d = tail_q + PW'(n_push);
                else         overflow_d = 1'b1;
            end
            head_d  = head_q + PW'(n_pop);
            count_d = count_q + (push_ok ? CW'(n_push) : '0) - n_pop;
        end
    end

    // State registers; array contents are intentionally left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign wr_en = push_valid_i & {IN_LANES{push_ok && !flush_i}};

    for (genvar k = 0; k < IN_LANES; k++) begin : g_wr
        iq_entry_t e;
        assign e.inst = push_inst_i[k*InstBus +: InstBus];
        assign e.pc   = push_pc_i[k*InstAddrBus +: InstAddrBus];
`ifdef INSTQ_BPU_INFO_EN
        assign e.bpu  = push_bpu_i[k*BpuInfoWidth +: BpuInfoWidth];
`endif
        assign wr_data[k*EntryW +: EntryW] = e;
    end

    inst_queue_mem #(
        .DEPTH     (DEPTH),
        .W         (EntryW),
        .IN_LANES  (IN_LANES),
        .OUT_LANES (OUT_LANES)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_en),
        .wbase_i (tail_q),
        .wdata_i (wr_data),
        .rbase_i (head_q),
        .rdata_o (rd_data)
    );

    // Invalid lanes drive zeros so stale array contents never leak to issue.
    for (genvar k = 0; k < OUT_LANES; k++) begin : g_out
        iq_entry_t e;
        assign out_valid_o[k] = count_q > CW'(k);
        assign e = out_valid_o[k] ? iq_entry_t'(rd_data[k*EntryW +: EntryW]) : '0;
        assign out_inst_o[k*InstBus +: InstBus]         = e.inst;
        assign out_pc_o[k*InstAddrBus +: InstAddrBus]   = e.pc;
`ifdef INSTQ_BPU_INFO_EN
        assign out_bpu_o[k*BpuInfoWidth +: BpuInfoWidth] = e.bpu;
`endif
    end

    assign count_o       = count_q;
    assign empty_o       = (count_q == '0);
    assign full_o        = (count_q == CW'(DEPTH));
    assign almost_full_o = (CW'(DEPTH) - count_q) < CW'(AFULL_SLACK);
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: stimulus pushes expected snapshots,
// a negedge monitor pops and compares them against the outputs.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = 32, IN_LANES = 2, OUT_LANES = 2, AFULL_SLACK = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic [1:0]  push_valid_i = '0;
    logic [63:0] push_inst_i = '0;
    logic [63:0] push_pc_i = '0;
    logic [65:0] push_bpu_i = '0;
    logic [1:0]  pop_num_i = '0;
    logic [1:0]  out_valid_o;
    logic [63:0] out_inst_o, out_pc_o;
    logic [65:0] out_bpu_o;
    logic [5:0]  count_o;
    logic        empty_o, full_o, almost_full_o, overflow_o;

    always #5 clk = ~clk;

    inst_queue #(.DEPTH(DEPTH), .IN_LANES(IN_LANES), .OUT_LANES(OUT_LANES),
                 .AFULL_SLACK(AFULL_SLACK)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .push_valid_i(push_valid_i), .push_inst_i(push_inst_i), .push_pc_i(push_pc_i),
`ifdef INSTQ_BPU_INFO_EN
        .push_bpu_i(push_bpu_i),
`endif
        .pop_num_i(pop_num_i),
        .out_valid_o(out_valid_o), .out_inst_o(out_inst_o), .out_pc_o(out_pc_o),
`ifdef INSTQ_BPU_INFO_EN
        .out_bpu_o(out_bpu_o),
`endif
        .count_o(count_o), .empty_o(empty_o), .full_o(full_o),
        .almost_full_o(almost_full_o), .overflow_o(overflow_o)
    );

`ifndef INSTQ_BPU_INFO_EN
    assign out_bpu_o = '0;
`endif

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [32:0] bpu;
    } ent_t;

    typedef struct {
        logic [5:0]  cnt;
        logic [1:0]  vld;
        logic [63:0] pc;
        logic [63:0] inst;
        logic [65:0] bpu;
        logic        emp, ful, af, ovf;
    } rec_t;

    ent_t model[$];
    logic m_ovf = 1'b0;
    rec_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic ent_t mk_ent(logic [31:0] pc);
        ent_t e;
        e.pc   = pc;
        e.inst = pc ^ 32'h5A5A_0000;
        e.bpu  = {1'b1, pc};
        return e;
    endfunction

    // Expected snapshot: count and flags from the hand-computed occupancy,
    // lane contents from the queue model.
    function automatic rec_t make_rec(int exp_cnt);
        rec_t r;
        r.cnt  = 6'(exp_cnt);
        r.emp  = (exp_cnt == 0);
        r.ful  = (exp_cnt == DEPTH);
        r.af   = (DEPTH - exp_cnt) < AFULL_SLACK;
        r.ovf  = m_ovf;
        r.vld  = '0;
        r.pc   = '0;
        r.inst = '0;
        r.bpu  = '0;
        for (int k = 0; k < OUT_LANES; k++) begin
            if (k < model.size()) begin
                r.vld[k]           = 1'b1;
                r.pc[k*32 +: 32]   = model[k].pc;
                r.inst[k*32 +: 32] = model[k].inst;
                r.bpu[k*33 +: 33]  = model[k].bpu;
            end
        end
        return r;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    // Monitor: one snapshot per falling edge.
    always @(negedge clk) begin
        rec_t r;
        if (sb.size() != 0) begin
            r = sb.pop_front();
            chk("count", 128'(count_o), 128'(r.cnt));
            chk("valid", 128'(out_valid_o), 128'(r.vld));
            chk("pc", 128'(out_pc_o), 128'(r.pc));
            chk("inst", 128'(out_inst_o), 128'(r.inst));
            chk("empty", 128'(empty_o), 128'(r.emp));
            chk("full", 128'(full_o), 128'(r.ful));
            chk("almost_full", 128'(almost_full_o), 128'(r.af));
            chk("overflow", 128'(overflow_o), 128'(r.ovf));
`ifdef INSTQ_BPU_INFO_EN
            chk("bpu", 128'(out_bpu_o), 128'(r.bpu));
`endif
        end
    end

    always @(posedge clk) begin
        assert ((push_valid_i & (push_valid_i + 2'd1)) == 2'b00)
            else $error("FAIL contiguity mask=%b", push_valid_i);
    end

    // Drive one cycle of stimulus, update the model, queue the expected snapshot.
    task automatic step(logic [1:0] mask, logic [31:0] pc0, int pop, logic fl, int exp_cnt);
        int old, np, npop;
        ent_t e;
        push_valid_i = mask;
        for (int k = 0; k < IN_LANES; k++) begin
            e = mk_ent(pc0 + 32'(4*k));
            push_pc_i[k*32 +: 32]   = e.pc;
            push_inst_i[k*32 +: 32] = e.inst;
            push_bpu_i[k*33 +: 33]  = e.bpu;
        end
        pop_num_i = 2'(pop);
        flush_i   = fl;
        old = model.size();
        np  = int'(mask[0]) + int'(mask[1]);
        if (fl) begin
            model.delete();
            m_ovf = 1'b0;
        end else begin
            if (old + np <= DEPTH) begin
                for (int k = 0; k < np; k++) model.push_back(mk_ent(pc0 + 32'(4*k)));
            end else if (np > 0) begin
                m_ovf = 1'b1;
            end
            npop = pop;
            if (npop > old) npop = old;
            if (npop > OUT_LANES) npop = OUT_LANES;
            repeat (npop) void'(model.pop_front());
        end
        @(posedge clk);
        #1;
        sb.push_back(make_rec(exp_cnt));
        push_valid_i = '0;
        pop_num_i    = '0;
        flush_i      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        sb.push_back(make_rec(0));

        step(2'b11, 32'h100, 0, 1'b0, 2);
        step(2'b00, 32'h0, 2, 1'b0, 0);

        for (int i = 0; i < 16; i++) step(2'b11, 32'h200 + 32'(8*i), 0, 1'b0, 2*(i+1));
        step(2'b11, 32'hF00, 0, 1'b0, 32);

        step(2'b11, 32'h900, 2, 1'b1, 0);

        for (int i = 0; i < 15; i++) step(2'b11, 32'h300 + 32'(8*i), 0, 1'b0, 2*(i+1));
        step(2'b01, 32'h400, 0, 1'b0, 31);
        step(2'b11, 32'hF10, 2, 1'b0, 29);

        for (int i = 0; i < 14; i++) step(2'b00, 32'h0, 2, 1'b0, 29 - 2*(i+1));
        step(2'b00, 32'h0, 2, 1'b0, 0);

        step(2'b11, 32'hA00, 0, 1'b0, 2);
        step(2'b00, 32'h0, 2, 1'b0, 0);

        step(2'b11, 32'hB00, 0, 1'b0, 2);
        step(2'b11, 32'hB10, 1, 1'b0, 3);
        step(2'b01, 32'hB20, 2, 1'b0, 2);

        // Short reset pulse between clock edges must clear everything.
        @(negedge clk);
        #1 rst_n = 1'b0;
        model.delete();
        m_ovf = 1'b0;
        #1 sb.push_back(make_rec(0));
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;

        step(2'b11, 32'h40, 0, 1'b0, 2);
        step(2'b00, 32'h0, 2, 1'b0, 0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
